// File: rtl/ckpt_ras.sv
// ckpt_ras -- return address stack with checkpoint/restore for speculative
// call/return prediction.
//
// A circular stack of DEPTH return addresses. Calls push, returns pop, and a
// push on a full stack silently overwrites the oldest entry. Checkpoint slots
// capture the post-operation top pointer, occupancy and top value so that a
// mispredicted branch can roll the stack back; only the top entry is repaired
// on restore, deeper entries are taken as they currently stand.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   push_valid / push_addr    call dispatched, return address to push
//   pop_valid                 return dispatched
//   save_valid / save_id      capture a checkpoint into a slot
//   free_valid / free_id      release a checkpoint slot
//   restore_valid/restore_id  roll back to a checkpoint (non-live => flush)
//   flush                     clear the stack and all checkpoints
//   pred_valid / pred_addr    stack non-empty / current top-of-stack address
//   count                     occupied entries, 0..DEPTH
//   ckpt_live                 per-slot valid bits
module ckpt_ras #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 8,
  parameter  int NUM_CKPT = 4,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1,
  localparam int IW       = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push_valid,
  input  logic [XLEN-1:0]     push_addr,
  input  logic                pop_valid,
  input  logic                save_valid,
  input  logic [IW-1:0]       save_id,
  input  logic                free_valid,
  input  logic [IW-1:0]       free_id,
  input  logic                restore_valid,
  input  logic [IW-1:0]       restore_id,
  input  logic                flush,
  output logic                pred_valid,
  output logic [XLEN-1:0]     pred_addr,
  output logic [CW-1:0]       count,
  output logic [NUM_CKPT-1:0] ckpt_live
);

  logic [XLEN-1:0]     r_entries   [DEPTH];
  logic [PW-1:0]       r_tos;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_slot_tos  [NUM_CKPT];
  logic [CW-1:0]       r_slot_cnt  [NUM_CKPT];
  logic [XLEN-1:0]     r_slot_top  [NUM_CKPT];
  logic [NUM_CKPT-1:0] r_slot_live;

  // Result of the push/pop operation alone, before restore/flush override.
  logic [PW-1:0]   w_tos_op;
  logic [CW-1:0]   w_cnt_op;
  logic            w_push_wr;
  logic [PW-1:0]   w_push_idx;
  logic [XLEN-1:0] w_top_op;

  logic w_save_ok;
  logic w_free_ok;
  logic w_restore_hit;
  logic w_do_flush;
  logic w_do_restore;
  logic w_do_stack;

  always_comb begin
    w_tos_op   = r_tos;
    w_cnt_op   = r_cnt;
    w_push_wr  = 1'b0;
    w_push_idx = r_tos;
    if (push_valid && pop_valid && (r_cnt != '0)) begin
      // Return-then-call: replace the top in place.
      w_push_wr = 1'b1;
    end else if (push_valid) begin
      w_tos_op   = r_tos + PW'(1);
      w_push_idx = r_tos + PW'(1);
      w_push_wr  = 1'b1;
      w_cnt_op   = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + CW'(1);
    end else if (pop_valid && (r_cnt != '0)) begin
      w_tos_op = r_tos - PW'(1);
      w_cnt_op = r_cnt - CW'(1);
    end
    // A push always writes the new top, so the saved top value bypasses it.
    w_top_op = w_push_wr ? push_addr : r_entries[w_tos_op];
  end

  assign w_save_ok     = save_valid && (32'(save_id) < NUM_CKPT);
  assign w_free_ok     = free_valid && (32'(free_id) < NUM_CKPT);
  assign w_restore_hit = restore_valid && (32'(restore_id) < NUM_CKPT)
                         && r_slot_live[restore_id];
  // A restore that names a dead or out-of-range slot degrades to a flush.
  assign w_do_flush    = flush || (restore_valid && !w_restore_hit);
  assign w_do_restore  = !flush && w_restore_hit;
  assign w_do_stack    = !flush && !restore_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_tos <= PW'(DEPTH - 1);
      r_cnt <= '0;
    end else if (w_do_flush) begin
      r_tos <= PW'(DEPTH - 1);
      r_cnt <= '0;
    end else if (w_do_restore) begin
      r_tos <= r_slot_tos[restore_id];
      r_cnt <= r_slot_cnt[restore_id];
      r_entries[r_slot_tos[restore_id]] <= r_slot_top[restore_id];
    end else begin
      r_tos <= w_tos_op;
      r_cnt <= w_cnt_op;
      if (w_push_wr) r_entries[w_push_idx] <= push_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        r_slot_tos[s] <= '0;
        r_slot_cnt[s] <= '0;
        r_slot_top[s] <= '0;
      end
      r_slot_live <= '0;
    end else if (w_do_flush) begin
      r_slot_live <= '0;
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        // Save (only without a restore) beats a same-slot free.
        if (w_do_stack && w_save_ok && (32'(save_id) == s)) begin
          r_slot_tos[s]  <= w_tos_op;
          r_slot_cnt[s]  <= w_cnt_op;
          r_slot_top[s]  <= w_top_op;
          r_slot_live[s] <= 1'b1;
        end else if (w_free_ok && (32'(free_id) == s)) begin
          r_slot_live[s] <= 1'b0;
        end
      end
    end
  end

  assign pred_valid = (r_cnt != '0);
  assign pred_addr  = r_entries[r_tos];
  assign count      = r_cnt;
  assign ckpt_live  = r_slot_live;

endmodule

// File: tb/tb_ckpt_ras.sv
module tb_ckpt_ras;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int NUM_CKPT = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            push_valid;
  logic [XLEN-1:0] push_addr;
  logic            pop_valid;
  logic            save_valid;
  logic [IW-1:0]   save_id;
  logic            free_valid;
  logic [IW-1:0]   free_id;
  logic            restore_valid;
  logic [IW-1:0]   restore_id;
  logic            flush;
  logic            pred_valid;
  logic [XLEN-1:0] pred_addr;
  logic [CW-1:0]   count;
  logic [NUM_CKPT-1:0] ckpt_live;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  ckpt_ras #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_CKPT(NUM_CKPT)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_addr(push_addr), .pop_valid(pop_valid),
    .save_valid(save_valid), .save_id(save_id),
    .free_valid(free_valid), .free_id(free_id),
    .restore_valid(restore_valid), .restore_id(restore_id),
    .flush(flush),
    .pred_valid(pred_valid), .pred_addr(pred_addr), .count(count),
    .ckpt_live(ckpt_live)
  );

  // Reference model: a DEPTH-entry ring of return addresses with a top index
  // and an occupancy count, plus a table of checkpoints.
  logic [31:0] m_ent [DEPTH];
  int          m_tos;
  int          m_cnt;
  int          c_tos [NUM_CKPT];
  int          c_cnt [NUM_CKPT];
  logic [31:0] c_top [NUM_CKPT];
  bit          c_live [NUM_CKPT];

  function automatic logic [3:0] model_live();
    logic [3:0] v;
    for (int s = 0; s < NUM_CKPT; s++) v[s] = c_live[s];
    return v;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_ent[i] = 0;
      m_tos = DEPTH - 1;
      m_cnt = 0;
      for (int s = 0; s < NUM_CKPT; s++) begin
        c_tos[s] = 0; c_cnt[s] = 0; c_top[s] = 0; c_live[s] = 0;
      end
    end else if (flush || (restore_valid && !c_live[restore_id])) begin
      m_tos = DEPTH - 1;
      m_cnt = 0;
      for (int s = 0; s < NUM_CKPT; s++) c_live[s] = 0;
    end else if (restore_valid) begin
      m_tos = c_tos[restore_id];
      m_cnt = c_cnt[restore_id];
      m_ent[m_tos] = c_top[restore_id];
      if (free_valid) c_live[free_id] = 0;
    end else begin
      if (push_valid && pop_valid && m_cnt > 0) begin
        m_ent[m_tos] = push_addr;
      end else if (push_valid) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_ent[m_tos] = push_addr;
        m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
      end else if (pop_valid && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end
      if (free_valid) c_live[free_id] = 0;
      if (save_valid) begin
        c_tos[save_id] = m_tos;
        c_cnt[save_id] = m_cnt;
        c_top[save_id] = m_ent[m_tos];
        c_live[save_id] = 1;
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic idle_inputs();
    reset = 0; push_valid = 0; push_addr = 0; pop_valid = 0;
    save_valid = 0; save_id = 0; free_valid = 0; free_id = 0;
    restore_valid = 0; restore_id = 0; flush = 0;
  endtask

  // One transaction: clock edge, advance the model, sample 1 time unit later.
  task automatic cycle(string tag);
    @(posedge clock);
    model_step();
    #1;
    $display("%-10s rst=%0b fl=%0b push=%0b/%h pop=%0b save=%0b/%0d free=%0b/%0d rest=%0b/%0d -> v=%0b top=%h cnt=%0d live=%b",
             tag, reset, flush, push_valid, push_addr, pop_valid, save_valid, save_id,
             free_valid, free_id, restore_valid, restore_id,
             pred_valid, pred_addr, count, ckpt_live);
    check({tag, ".pred_valid"}, 32'(pred_valid), 32'(m_cnt != 0));
    check({tag, ".pred_addr"},  pred_addr, m_ent[m_tos]);
    check({tag, ".count"},      32'(count), 32'(m_cnt));
    check({tag, ".ckpt_live"},  32'(ckpt_live), 32'(model_live()));
    idle_inputs();
  endtask

  task automatic push_op(logic [31:0] a, string tag);
    push_valid = 1; push_addr = a; cycle(tag);
  endtask

  task automatic expect_out(string tag, logic v, logic [31:0] a, int c);
    check({tag, ".v"},   32'(pred_valid), 32'(v));
    check({tag, ".top"}, pred_addr, a);
    check({tag, ".cnt"}, 32'(count), c);
  endtask

  initial begin
    idle_inputs();
    reset = 1; cycle("reset");
    reset = 1; cycle("reset");
    expect_out("reset", 0, 32'h0, 0);
    check("reset.live", 32'(ckpt_live), 0);

    // Basic push / pop
    push_op(32'h100, "push"); push_op(32'h200, "push"); push_op(32'h300, "push");
    expect_out("push3", 1, 32'h300, 3);
    pop_valid = 1; cycle("pop");
    expect_out("pop1", 1, 32'h200, 2);

    // Overflow wraps, then drain to empty and underflow
    flush = 1; cycle("flush");
    push_op(32'h10, "push"); push_op(32'h20, "push"); push_op(32'h30, "push");
    push_op(32'h40, "push"); push_op(32'h50, "push");
    expect_out("ovfl", 1, 32'h50, 4);
    pop_valid = 1; cycle("pop"); expect_out("drain1", 1, 32'h40, 3);
    pop_valid = 1; cycle("pop"); expect_out("drain2", 1, 32'h30, 2);
    pop_valid = 1; cycle("pop"); expect_out("drain3", 1, 32'h20, 1);
    pop_valid = 1; cycle("pop"); check("drain4.v", 32'(pred_valid), 0);
    pop_valid = 1; cycle("underflow"); check("underflow.cnt", 32'(count), 0);

    // Simultaneous push and pop
    flush = 1; cycle("flush");
    push_op(32'h10, "push"); push_op(32'h20, "push");
    push_valid = 1; push_addr = 32'h99; pop_valid = 1; cycle("pushpop");
    expect_out("pushpop", 1, 32'h99, 2);
    flush = 1; cycle("flush");
    push_valid = 1; push_addr = 32'h99; pop_valid = 1; cycle("pushpop0");
    expect_out("pushpop0", 1, 32'h99, 1);

    // Checkpoint restore repairs an overwritten top
    flush = 1; cycle("flush");
    push_valid = 1; push_addr = 32'hA0; save_valid = 1; save_id = 2; cycle("push+save");
    pop_valid = 1; cycle("pop");
    push_op(32'hB0, "push");
    restore_valid = 1; restore_id = 2; cycle("restore");
    expect_out("restore", 1, 32'hA0, 1);
    check("restore.live2", 32'(ckpt_live[2]), 1);

    // Restore of a freed slot behaves as flush; flush beats push
    free_valid = 1; free_id = 2; cycle("free");
    push_op(32'hC0, "push");
    restore_valid = 1; restore_id = 2; cycle("rest_dead");
    expect_out("rest_dead", 0, pred_addr, 0);
    check("rest_dead.live", 32'(ckpt_live), 0);
    push_op(32'hD0, "push");
    flush = 1; push_valid = 1; push_addr = 32'hE0; cycle("flush+push");
    check("flush+push.cnt", 32'(count), 0);
    check("flush+push.live", 32'(ckpt_live), 0);

    // Save beats free on the same slot; reset beats push
    save_valid = 1; save_id = 1; free_valid = 1; free_id = 1; cycle("save+free");
    check("save+free.live1", 32'(ckpt_live[1]), 1);
    push_op(32'h77, "push");
    reset = 1; push_valid = 1; push_addr = 32'h88; cycle("rst+push");
    expect_out("rst+push", 0, 32'h0, 0);
    check("rst+push.live", 32'(ckpt_live), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      push_valid    = $urandom_range(0, 1);
      push_addr     = $urandom;
      pop_valid     = $urandom_range(0, 1);
      save_valid    = ($urandom_range(0, 3) == 0);
      save_id       = IW'($urandom_range(0, 3));
      free_valid    = ($urandom_range(0, 3) == 0);
      free_id       = IW'($urandom_range(0, 3));
      restore_valid = ($urandom_range(0, 9) == 0);
      restore_id    = IW'($urandom_range(0, 3));
      flush         = ($urandom_range(0, 39) == 0);
      reset         = ($urandom_range(0, 79) == 0);
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
